inst_boot_loader: RTL and testbench

Upstream feeder for the minimal SOPC. It receives a framed byte stream (valid/ready) carrying a program image and assembles big-endian 32-bit instruction words. It writes those words sequentially into instruction memory through a simple write port, holding the CPU's reset asserted until a complete, checksum-verified image has been written. After verification it releases CPU reset following a fixed delay; it also supports re-loading while the CPU runs.

---
 rtl/inst_boot_loader.sv | 166 ++++++++++++++++
 tb/tb_inst_boot_loader.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/inst_boot_loader.sv
// Boot loader: receives a framed byte image, writes 32-bit words to
// instruction memory and holds cpu_rst until the image checksum is verified.
//
// Ports:
//   clk, rst             clock and synchronous active-high reset
//   in_valid/in_data     byte stream in; in_ready = byte accepted
//   mem_we/addr/wdata    instruction-memory write port (one-cycle pulses)
//   cpu_rst              CPU reset, low only while a verified image runs
//   done                 verified image running
//   err                  sticky error (bad length or checksum)
module inst_boot_loader #(
  parameter int ADDR_W      = 10,
  parameter int MAX_WORDS   = 1024,
  parameter int RELEASE_DLY = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_rst,
  output logic              done,
  output logic              err
);

  typedef enum logic [2:0] {
    IDLE, LEN_HI, LEN_LO, DATA, CSUM, RELEASE, RUN
  } state_t;

  localparam int DW = (RELEASE_DLY > 1) ? $clog2(RELEASE_DLY) : 1;
  localparam logic [16:0]   MAX_N    = 17'(MAX_WORDS);
  localparam logic [DW-1:0] DLY_LAST = DW'(RELEASE_DLY - 1);
  localparam logic [7:0]    SYNC     = 8'hA5;

  state_t            state, state_nxt;
  logic [7:0]        len_hi, len_hi_nxt;
  logic [15:0]       words_left, words_left_nxt;
  logic [1:0]        bcnt, bcnt_nxt;
  logic [23:0]       shreg, shreg_nxt;
  logic [7:0]        csum, csum_nxt;
  logic [ADDR_W-1:0] waddr, waddr_nxt;
  logic [DW-1:0]     dly, dly_nxt;
  logic              we_nxt;
  logic [ADDR_W-1:0] addr_nxt;
  logic [31:0]       wdata_nxt;
  logic              err_nxt;
  logic              acc;
  logic [15:0]       n_rx;

  assign in_ready = !rst && (state != RELEASE);
  assign acc      = in_valid && in_ready;
  assign n_rx     = {len_hi, in_data};
  assign cpu_rst  = (state != RUN);
  assign done     = (state == RUN);

  always_comb begin
    state_nxt      = state;
    len_hi_nxt     = len_hi;
    words_left_nxt = words_left;
    bcnt_nxt       = bcnt;
    shreg_nxt      = shreg;
    csum_nxt       = csum;
    waddr_nxt      = waddr;
    dly_nxt        = dly;
    we_nxt         = 1'b0;
    addr_nxt       = mem_addr;
    wdata_nxt      = mem_wdata;
    err_nxt        = err;
    unique case (state)
      IDLE, RUN: begin
        if (acc && in_data == SYNC) begin
          state_nxt = LEN_HI;
          err_nxt   = 1'b0;
          csum_nxt  = 8'h00;
          bcnt_nxt  = 2'd0;
        end
      end
      LEN_HI: begin
        if (acc) begin
          len_hi_nxt = in_data;
          state_nxt  = LEN_LO;
        end
      end
      LEN_LO: begin
        if (acc) begin
          words_left_nxt = n_rx;
          if ({1'b0, n_rx} > MAX_N) begin
            state_nxt = IDLE;
            err_nxt   = 1'b1;
          end else if (n_rx == 16'd0) begin
            state_nxt = CSUM;
          end else begin
            state_nxt = DATA;
            waddr_nxt = '0;
            bcnt_nxt  = 2'd0;
          end
        end
      end
      DATA: begin
        if (acc) begin
          csum_nxt  = csum ^ in_data;
          shreg_nxt = {shreg[15:0], in_data};
          bcnt_nxt  = bcnt + 2'd1;
          if (bcnt == 2'd3) begin
            we_nxt         = 1'b1;
            addr_nxt       = waddr;
            wdata_nxt      = {shreg, in_data};
            waddr_nxt      = waddr + ADDR_W'(1);
            words_left_nxt = words_left - 16'd1;
            if (words_left == 16'd1) state_nxt = CSUM;
          end
        end
      end
      CSUM: begin
        if (acc) begin
          if (in_data == csum) begin
            state_nxt = RELEASE;
            dly_nxt   = '0;
          end else begin
            state_nxt = IDLE;
            err_nxt   = 1'b1;
          end
        end
      end
      RELEASE: begin
        if (dly == DLY_LAST) state_nxt = RUN;
        else dly_nxt = dly + DW'(1);
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      len_hi     <= 8'h00;
      words_left <= 16'd0;
      bcnt       <= 2'd0;
      shreg      <= 24'd0;
      csum       <= 8'h00;
      waddr      <= '0;
      dly        <= '0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= 32'd0;
      err        <= 1'b0;
    end else begin
      state      <= state_nxt;
      len_hi     <= len_hi_nxt;
      words_left <= words_left_nxt;
      bcnt       <= bcnt_nxt;
      shreg      <= shreg_nxt;
      csum       <= csum_nxt;
      waddr      <= waddr_nxt;
      dly        <= dly_nxt;
      mem_we     <= we_nxt;
      mem_addr   <= addr_nxt;
      mem_wdata  <= wdata_nxt;
      err        <= err_nxt;
    end
  end

endmodule

// File: tb/tb_inst_boot_loader.sv
// Self-checking bench for inst_boot_loader: directed frames plus
// randomized frames/valid gaps against a frame-level reference model.
module tb_inst_boot_loader;

  localparam int ADDR_W = 10;
  localparam int MAXW   = 1024;
  localparam int DLY    = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic [7:0]        in_data = 8'h00;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              cpu_rst;
  logic              done;
  logic              err;

  inst_boot_loader #(
    .ADDR_W(ADDR_W), .MAX_WORDS(MAXW), .RELEASE_DLY(DLY)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_rst(cpu_rst), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [ADDR_W-1:0] a;
    logic [31:0]       d;
  } wr_t;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          vprob = 100;
  bit          abort = 0;
  bit          ready_drop = 0;
  wr_t         got_q[$];
  wr_t         exp_q[$];
  logic [7:0]  frm[$];
  logic [31:0] words[$];

  always @(negedge clk)
    if (mem_we) got_q.push_back('{a: mem_addr, d: mem_wdata});

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int t = 0;
    bit a = 0;
    if (abort) return;
    while (!a) begin
      @(negedge clk);
      in_valid = ($urandom_range(99) < vprob);
      in_data  = b;
      #1;
      if (in_valid && !in_ready) ready_drop = 1;
      a = in_valid && in_ready;
      t++;
      if (!a && t > 300) begin
        n_cmp++;
        n_bad++;
        $display("FAIL accept_timeout observed=no_accept expected=accept byte=%0h", b);
        abort = 1;
        in_valid = 1'b0;
        return;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic expect_release(input string tag);
    int k = 0;
    chk({tag, "_rdy_lo"}, in_ready, 0);
    while (k < 50) begin
      @(posedge clk);
      #1;
      k++;
      if (!cpu_rst) break;
    end
    chk({tag, "_lat"}, k, DLY);
    chk({tag, "_done"}, done, 1);
    chk({tag, "_err"}, err, 0);
  endtask

  // Reference: build frame bytes and the expected write list from words[].
  task automatic run_frame(input string tag, input bit bad,
                           input bit chk_sync);
    logic [7:0] cs = 8'h00;
    logic [7:0] b;
    int n = words.size();
    int v = 0;
    frm.delete();
    exp_q.delete();
    frm.push_back(8'hA5);
    frm.push_back(8'(n >> 8));
    frm.push_back(8'(n));
    for (int i = 0; i < n; i++) begin
      for (int j = 3; j >= 0; j--) begin
        b = 8'(words[i] >> (8 * j));
        frm.push_back(b);
        cs = cs ^ b;
      end
      exp_q.push_back('{a: ADDR_W'(i), d: words[i]});
    end
    frm.push_back(bad ? (cs ^ 8'h5A) : cs);
    got_q.delete();
    for (int i = 0; i < frm.size(); i++) begin
      send_byte(frm[i]);
      if (i == 0 && chk_sync) begin
        chk({tag, "_sync_rst"}, cpu_rst, 1);
        chk({tag, "_sync_done"}, done, 0);
      end
    end
    if (!bad) begin
      expect_release(tag);
    end else begin
      chk({tag, "_err"}, err, 1);
      repeat (100) begin
        @(negedge clk);
        if (cpu_rst !== 1'b1 || done !== 1'b0) v++;
      end
      chk({tag, "_hold"}, v, 0);
    end
    chk({tag, "_nwr"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      if (i < got_q.size())
        chk({tag, "_wr"}, got_q[i], exp_q[i]);
  endtask

  initial begin
    logic [7:0] g;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", in_ready, 0);
    chk("rst_cpu", cpu_rst, 1);
    chk("rst_we", mem_we, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    @(negedge clk);
    rst = 1'b0;

    words = '{32'h34011100, 32'h34020020};
    run_frame("s1", 0, 0);

    run_frame("s2bad", 1, 0);
    run_frame("s2ok", 0, 0);

    got_q.delete();
    send_byte(8'h00);
    send_byte(8'hFF);
    send_byte(8'h12);
    chk("s3_run_cpu", cpu_rst, 0);
    words.delete();
    run_frame("s3", 0, 0);

    got_q.delete();
    send_byte(8'hA5);
    send_byte(8'h04);
    send_byte(8'h01);
    chk("s4_err", err, 1);
    chk("s4_cpu", cpu_rst, 1);
    chk("s4_done", done, 0);
    for (int i = 0; i < 8; i++) begin
      g = 8'($urandom);
      if (g == 8'hA5) g = 8'h5A;
      send_byte(g);
    end
    repeat (3) @(negedge clk);
    chk("s4_nwr", got_q.size(), 0);
    chk("s4_err_hold", err, 1);

    words = '{32'h34011100, 32'h34020020};
    vprob = 50;
    ready_drop = 0;
    run_frame("s5", 0, 0);
    chk("s5_ready_hold", ready_drop, 0);
    vprob = 100;

    send_byte(8'hA5);
    send_byte(8'h00);
    send_byte(8'h02);
    send_byte(8'h34);
    send_byte(8'h01);
    send_byte(8'h11);
    send_byte(8'h00);
    send_byte(8'h34);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("s6_ready", in_ready, 0);
    chk("s6_cpu", cpu_rst, 1);
    chk("s6_we", mem_we, 0);
    chk("s6_addr", mem_addr, 0);
    chk("s6_wdata", mem_wdata, 0);
    chk("s6_done", done, 0);
    chk("s6_err", err, 0);
    @(negedge clk);
    rst = 1'b0;
    run_frame("s6", 0, 0);
    words = '{32'h00000000};
    run_frame("s6r", 0, 1);

    for (int r = 0; r < 6; r++) begin
      words.delete();
      for (int i = 0; i < int'($urandom_range(1, 6)); i++)
        words.push_back($urandom);
      vprob = int'($urandom_range(40, 100));
      run_frame("rnd", ($urandom_range(3) == 0), 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
